controlador_acesso_autenticacao: RTL and testbench
==================================================

# controlador_acesso_autenticacao

Sequential access controller placed directly downstream of the combinational authentication comparator. It samples the comparator's three authentication flags AUT1, AUT2 and AUT3 when a validation strobe arrives. On a match it grants access at a priority level for a timed window. It counts consecutive failures and, optionally, locks the system out for a timed period.

## Interface
Parameters:
- MAX_TENT, 3: consecutive failed attempts that trigger lockout (≥1).
- T_ABERTO, 8: cycles LIBERADO stays high per grant (≥1).
- T_BLOQUEIO, 16: cycles BLOQUEADO stays high per lockout (≥1).

Ports:
- CLK  in  1: single clock, all logic on rising edge.
- RST  in  1: reset, synchronous, active-high.
- AUT1  in  1: comparator flag, level 1 (highest priority).
- AUT2  in  1: comparator flag, level 2.
- AUT3  in  1: comparator flag, level 3.
- VALIDAR  in  1: submit strobe. Sampled only in IDLE.
- LIBERADO  out  1: access granted window.
- NIVEL  out  2: granted level, 1/2/3. 0 when not granted.
- NEGADO  out  1: one-cycle pulse per rejected attempt.
- BLOQUEADO  out  1: lockout active.
- TENTATIVAS  out  $clog2(MAX_TENT+1): current consecutive-failure count.

## Operation
- FSM states: IDLE, LIBERA, NEGA, BLOQUEIO.
- Reset: state=IDLE. LIBERADO=0, NIVEL=0, NEGADO=0, BLOQUEADO=0, TENTATIVAS=0, timer=0.
- IDLE, VALIDAR=1: AUT flags sampled on that edge.
  - Any flag set: go to LIBERA. NIVEL = lowest-index set flag (AUT1→1, AUT2→2, AUT3→3). TENTATIVAS cleared.
  - No flag set: go to NEGA. TENTATIVAS increments, saturating at MAX_TENT.
- IDLE, VALIDAR=0: stay in IDLE. AUT inputs ignored.
- LIBERA: LIBERADO=1 and NIVEL held for exactly T_ABERTO cycles, then IDLE with NIVEL=0.
- NEGA: lasts one cycle with NEGADO=1. Next state is BLOQUEIO if TENTATIVAS==MAX_TENT, else IDLE.
- BLOQUEIO: BLOQUEADO=1 for exactly T_BLOQUEIO cycles. Exit goes to IDLE with TENTATIVAS=0.
- VALIDAR is ignored in every state except IDLE. A strobe held high re-submits on the first IDLE cycle.
- AUT inputs are read only on the accepting edge. Later input changes do not affect the active state.
- Timer is a down-counter.
  - Loaded with T-1 on entry to LIBERA or BLOQUEIO.
  - State exits on the cycle the timer reads 0.
  - Width: $clog2(max(T_ABERTO,T_BLOQUEIO)).
- RST has priority over all other inputs, including mid-grant and mid-lockout. The block returns to reset values on the next edge.

## Timing
- Registered Moore outputs. No combinational path from input to output.
- VALIDAR sampled at edge n: LIBERADO or NEGADO high from edge n+1.
- Grant: LIBERADO high for cycles n+1 … n+T_ABERTO. The next VALIDAR is accepted at edge n+T_ABERTO+1 at the earliest.
- Reject without lockout: NEGADO high for cycle n+1 only. Next accept at edge n+2.
- Reject with lockout: NEGADO at n+1, BLOQUEADO for cycles n+2 … n+1+T_BLOQUEIO.
- TENTATIVAS updates on the same edge the state leaves IDLE.

## Configuration
- AUT_BLOQUEIO_EN defined: the BLOQUEIO state, its timer load and the BLOQUEADO output are present, as described above.
- AUT_BLOQUEIO_EN undefined:
  - No BLOQUEIO state. NEGA always returns to IDLE.
  - BLOQUEADO is tied to 0.
  - TENTATIVAS still counts and saturates at MAX_TENT, and clears on a grant.

## Structure
- Shared package autenticacao_pkg holds:
  - state encoding localparams: IDLE=2'd0, LIBERA=2'd1, NEGA=2'd2, BLOQUEIO=2'd3;
  - NIVEL encodings: NIVEL_NENHUM=0, NIVEL_1..NIVEL_3.
- One sub-module, temporizador_autenticacao: loadable down-counter with ports load, value, zero flag. It is shared by LIBERA and BLOQUEIO.

## Test plan
- Reset to IDLE, then VALIDAR=1 with AUT1=1, AUT3=1 → LIBERADO=1, NIVEL=1 for 8 cycles, then IDLE, NIVEL=0.
- VALIDAR with only AUT3=1 → NIVEL=3, TENTATIVAS=0 after the grant.
- Three rejects (all AUT=0), with VALIDAR pulsed each time in IDLE → three NEGADO pulses, TENTATIVAS 1,2,3. BLOQUEADO high for 16 cycles after the third pulse. Then TENTATIVAS=0.
- VALIDAR held high during BLOQUEIO with AUT2=1 → no grant until BLOQUEADO falls. Grant with NIVEL=2 on the first IDLE edge.
- RST asserted on the 4th LIBERA cycle → next edge gives all outputs 0, state IDLE.
- Compiled without AUT_BLOQUEIO_EN, four rejects → four NEGADO pulses, BLOQUEADO constant 0, TENTATIVAS saturates at 3.

Source files
------------

// File: rtl/autenticacao_pkg.sv
// Shared definitions for the authentication access controller: state and level encodings.
// Optional lockout feature is selected by the AUT_BLOQUEIO_EN macro in the top module.
package autenticacao_pkg;

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] LIBERA   = 2'd1;
    localparam logic [1:0] NEGA     = 2'd2;
    localparam logic [1:0] BLOQUEIO = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE     = IDLE,
        S_LIBERA   = LIBERA,
        S_NEGA     = NEGA,
        S_BLOQUEIO = BLOQUEIO
    } estado_t;

    localparam logic [1:0] NIVEL_NENHUM = 2'd0;
    localparam logic [1:0] NIVEL_1      = 2'd1;
    localparam logic [1:0] NIVEL_2      = 2'd2;
    localparam logic [1:0] NIVEL_3      = 2'd3;

    // Lowest-index set flag wins; callers only use this when at least one flag is set.
    function automatic logic [1:0] nivel_prioridade(input logic aut1, input logic aut2,
                                                    input logic aut3);
        if (aut1)      return NIVEL_1;
        else if (aut2) return NIVEL_2;
        else if (aut3) return NIVEL_3;
        else           return NIVEL_NENHUM;
    endfunction

endpackage

// File: rtl/temporizador_autenticacao.sv
// Loadable down-counter shared by the grant window and the lockout period.
// Stops at zero; zero flag reflects the registered count.
module temporizador_autenticacao #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         zero
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = value;
        end else if (count_q != '0) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/controlador_acesso_autenticacao.sv
// Access controller: samples AUT1..AUT3 on VALIDAR, grants a timed window or counts failures.
// Define AUT_BLOQUEIO_EN to enable the timed lockout after MAX_TENT consecutive failures.
module controlador_acesso_autenticacao
    import autenticacao_pkg::*;
#(
    parameter int MAX_TENT   = 3,
    parameter int T_ABERTO   = 8,
    parameter int T_BLOQUEIO = 16
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          AUT1,
    input  logic                          AUT2,
    input  logic                          AUT3,
    input  logic                          VALIDAR,
    output logic                          LIBERADO,
    output logic [1:0]                    NIVEL,
    output logic                          NEGADO,
    output logic                          BLOQUEADO,
    output logic [$clog2(MAX_TENT+1)-1:0] TENTATIVAS
);

    localparam int TW   = $clog2(MAX_TENT + 1);
    localparam int TMAX = (T_ABERTO > T_BLOQUEIO) ? T_ABERTO : T_BLOQUEIO;
    localparam int TMW  = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam logic [TW-1:0] MAX_T = TW'(MAX_TENT);

    estado_t       estado_q, estado_d;
    logic [1:0]    nivel_q, nivel_d;
    logic [TW-1:0] tentativas_q, tentativas_d;
    logic          liberado_q, liberado_d;
    logic          negado_q, negado_d;
    logic          bloqueado_q, bloqueado_d;

    logic           tmr_load;
    logic [TMW-1:0] tmr_value;
    logic           tmr_zero;

    temporizador_autenticacao #(.W(TMW)) u_temporizador (
        .clk   (CLK),
        .rst   (RST),
        .load  (tmr_load),
        .value (tmr_value),
        .zero  (tmr_zero)
    );

    always_comb begin
        estado_d     = estado_q;
        nivel_d      = nivel_q;
        tentativas_d = tentativas_q;
        tmr_load     = 1'b0;
        tmr_value    = '0;

        case (estado_q)
            S_IDLE: begin
                if (VALIDAR) begin
                    if (AUT1 || AUT2 || AUT3) begin
                        estado_d     = S_LIBERA;
                        nivel_d      = nivel_prioridade(AUT1, AUT2, AUT3);
                        tentativas_d = '0;
                        tmr_load     = 1'b1;
                        tmr_value    = TMW'(T_ABERTO - 1);
                    end else begin
                        estado_d     = S_NEGA;
                        tentativas_d = (tentativas_q == MAX_T) ? MAX_T : tentativas_q + TW'(1);
                    end
                end
            end
            S_LIBERA: begin
                if (tmr_zero) begin
                    estado_d = S_IDLE;
                    nivel_d  = NIVEL_NENHUM;
                end
            end
            S_NEGA: begin
                estado_d = S_IDLE;
`ifdef AUT_BLOQUEIO_EN
                if (tentativas_q == MAX_T) begin
                    estado_d  = S_BLOQUEIO;
                    tmr_load  = 1'b1;
                    tmr_value = TMW'(T_BLOQUEIO - 1);
                end
`endif
            end
            S_BLOQUEIO: begin
                if (tmr_zero) begin
                    estado_d     = S_IDLE;
                    tentativas_d = '0;
                end
            end
            default: begin
                estado_d = S_IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they register alongside it.
        liberado_d  = (estado_d == S_LIBERA);
        negado_d    = (estado_d == S_NEGA);
`ifdef AUT_BLOQUEIO_EN
        bloqueado_d = (estado_d == S_BLOQUEIO);
`else
        bloqueado_d = 1'b0;
`endif
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            estado_q     <= S_IDLE;
            nivel_q      <= NIVEL_NENHUM;
            tentativas_q <= '0;
            liberado_q   <= 1'b0;
            negado_q     <= 1'b0;
            bloqueado_q  <= 1'b0;
        end else begin
            estado_q     <= estado_d;
            nivel_q      <= nivel_d;
            tentativas_q <= tentativas_d;
            liberado_q   <= liberado_d;
            negado_q     <= negado_d;
            bloqueado_q  <= bloqueado_d;
        end
    end

    assign LIBERADO   = liberado_q;
    assign NIVEL      = nivel_q;
    assign NEGADO     = negado_q;
    assign BLOQUEADO  = bloqueado_q;
    assign TENTATIVAS = tentativas_q;

endmodule

// File: tb/tb_controlador_acesso_autenticacao.sv
// Self-checking bench: directed scenarios plus random traffic against a countdown-based model.
// The lockout model follows AUT_BLOQUEIO_EN the same way the design build does.
module tb_controlador_acesso_autenticacao;

    localparam int MAX_TENT   = 3;
    localparam int T_ABERTO   = 8;
    localparam int T_BLOQUEIO = 16;
    localparam int TW         = $clog2(MAX_TENT + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          aut1, aut2, aut3, validar;
    logic          liberado, negado, bloqueado;
    logic [1:0]    nivel;
    logic [TW-1:0] tentativas;

    int checks = 0;
    int errors = 0;

    // Reference model: remaining-cycle counts rather than explicit states.
    int grantLeft = 0;
    int lockLeft  = 0;
    bit negPulse  = 0;
    int level     = 0;
    int fails     = 0;

    controlador_acesso_autenticacao #(
        .MAX_TENT   (MAX_TENT),
        .T_ABERTO   (T_ABERTO),
        .T_BLOQUEIO (T_BLOQUEIO)
    ) dut (
        .CLK        (clk),
        .RST        (rst),
        .AUT1       (aut1),
        .AUT2       (aut2),
        .AUT3       (aut3),
        .VALIDAR    (validar),
        .LIBERADO   (liberado),
        .NIVEL      (nivel),
        .NEGADO     (negado),
        .BLOQUEADO  (bloqueado),
        .TENTATIVAS (tentativas)
    );

    always #5 clk = ~clk;

    // Counts every comparison and reports any disagreement with the model.
    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, observed, expected, $time);
        end
    endtask

    // Advances the model by one clock edge with the given inputs.
    task automatic modelStep(input bit r, input bit v, input bit a1, input bit a2, input bit a3);
        if (r) begin
            grantLeft = 0; lockLeft = 0; negPulse = 0; level = 0; fails = 0;
        end else if (negPulse) begin
            negPulse = 0;
`ifdef AUT_BLOQUEIO_EN
            if (fails == MAX_TENT) lockLeft = T_BLOQUEIO;
`endif
        end else if (grantLeft > 0) begin
            grantLeft--;
            if (grantLeft == 0) level = 0;
        end else if (lockLeft > 0) begin
            lockLeft--;
            if (lockLeft == 0) fails = 0;
        end else if (v) begin
            if (a1 || a2 || a3) begin
                level     = a1 ? 1 : (a2 ? 2 : 3);
                fails     = 0;
                grantLeft = T_ABERTO;
            end else begin
                fails    = (fails + 1 > MAX_TENT) ? MAX_TENT : fails + 1;
                negPulse = 1;
            end
        end
    endtask

    // Drives one cycle of inputs, steps the model and checks all outputs after the edge.
    task automatic applyStimulus(input bit r, input bit v, input bit a1, input bit a2, input bit a3);
        @(negedge clk);
        rst = r; validar = v; aut1 = a1; aut2 = a2; aut3 = a3;
        modelStep(r, v, a1, a2, a3);
        @(posedge clk);
        #1;
        checkOutput("liberado",   int'(liberado),   int'(grantLeft > 0));
        checkOutput("nivel",      int'(nivel),      level);
        checkOutput("negado",     int'(negado),     int'(negPulse));
        checkOutput("bloqueado",  int'(bloqueado),  int'(lockLeft > 0));
        checkOutput("tentativas", int'(tentativas), fails);
    endtask

    initial begin
        rst = 1'b1; validar = 1'b0; aut1 = 1'b0; aut2 = 1'b0; aut3 = 1'b0;

        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(1, 1, 1, 1, 1);
        applyStimulus(0, 0, 1, 0, 0);

        // Grant with AUT1 and AUT3: level 1 wins, window then back to idle.
        applyStimulus(0, 1, 1, 0, 1);
        for (int i = 0; i < T_ABERTO + 1; i++)
            applyStimulus(0, 0, 1'($urandom), 1'($urandom), 1'($urandom));

        // Grant with AUT3 only.
        applyStimulus(0, 1, 0, 0, 1);
        for (int i = 0; i < T_ABERTO + 1; i++) applyStimulus(0, 0, 0, 0, 0);

        // Three rejects, then VALIDAR held with AUT2 through the lockout.
        for (int k = 0; k < MAX_TENT; k++) begin
            applyStimulus(0, 1, 0, 0, 0);
            applyStimulus(0, 0, 0, 0, 0);
        end
        for (int i = 0; i < T_BLOQUEIO + 4; i++) applyStimulus(0, 1, 0, 1, 0);
        for (int i = 0; i < T_ABERTO + 2; i++) applyStimulus(0, 0, 0, 0, 0);

        // Fourth reject to exercise saturation, then reset during a grant.
        for (int k = 0; k < MAX_TENT + 1; k++) begin
            applyStimulus(0, 1, 0, 0, 0);
            applyStimulus(0, 0, 0, 0, 0);
        end
        for (int i = 0; i < T_BLOQUEIO + 2; i++) applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 1, 1);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);

        // Random traffic biased toward rejects so lockout and saturation recur.
        for (int i = 0; i < 800; i++)
            applyStimulus(($urandom_range(0, 99) == 0),
                          ($urandom_range(0, 1) == 1),
                          ($urandom_range(0, 4) == 0),
                          ($urandom_range(0, 4) == 0),
                          ($urandom_range(0, 4) == 0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
